// File: rtl/leb128_pkg.sv
// Shared constants and state encoding for the signed-LEB128 int32 stream decoder.
package leb128_pkg;

  localparam int LEB128_I32_MAX_BYTES = 5;
  localparam int CONT_BIT = 7;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

endpackage

// File: rtl/unpack_i32.sv
// Combinational signed-LEB128 unpacker: five window bytes in, int32 value and byte length out.
module unpack_i32
  import leb128_pkg::*;
(
  input  logic [7:0]        i0,
  input  logic [7:0]        i1,
  input  logic [7:0]        i2,
  input  logic [7:0]        i3,
  input  logic [7:0]        i4,
  output logic signed [31:0] value,
  output logic [2:0]        len
);

  logic [31:0] raw;
  logic        unused_hi;

  // Only bits [3:0] of the fifth byte land inside 32 bits; its bit7 and [6:4] are don't-care.
  assign raw       = {i4[3:0], i3[6:0], i2[6:0], i1[6:0], i0[6:0]};
  assign unused_hi = ^{i4[7:4]};

  always_comb begin
    len = 3'd5;
    if (!i0[CONT_BIT])      len = 3'd1;
    else if (!i1[CONT_BIT]) len = 3'd2;
    else if (!i2[CONT_BIT]) len = 3'd3;
    else if (!i3[CONT_BIT]) len = 3'd4;
  end

  always_comb begin
    case (len)
      3'd1:    value = {{25{raw[6]}},  raw[6:0]};
      3'd2:    value = {{18{raw[13]}}, raw[13:0]};
      3'd3:    value = {{11{raw[20]}}, raw[20:0]};
      3'd4:    value = {{4{raw[27]}},  raw[27:0]};
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/leb128_i32_stream_decoder.sv
// Byte-stream sequencer around unpack_i32 with valid/ready in and out.
// Optional malformed-encoding flag on out_err when LEB128_DECODER_ERR_EN is defined.
module leb128_i32_stream_decoder
  import leb128_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic signed [31:0] out_data,
  output logic [2:0]         out_len,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   value_cnt
);

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] w [LEB128_I32_MAX_BYTES];
  logic       take;
  logic       term;
  logic       handoff;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == EMIT);
  assign take      = in_valid & in_ready;
  assign handoff   = out_valid & out_ready;
  assign term      = !in_data[CONT_BIT] || (cnt == 3'(LEB128_I32_MAX_BYTES - 1)) || in_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      cnt       <= '0;
      value_cnt <= '0;
      for (int i = 0; i < LEB128_I32_MAX_BYTES; i++) w[i] <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (take) begin
            for (int i = 0; i < LEB128_I32_MAX_BYTES; i++)
              if (cnt == 3'(i)) w[i] <= in_data;
            if (term) state <= EMIT;
            else      cnt   <= cnt + 3'd1;
          end
        end
        default: begin
          // Clearing the window keeps bytes above the next terminator at zero.
          if (handoff) begin
            state <= COLLECT;
            cnt   <= '0;
            for (int i = 0; i < LEB128_I32_MAX_BYTES; i++) w[i] <= '0;
            if (value_cnt != {CNT_W{1'b1}}) value_cnt <= value_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef LEB128_DECODER_ERR_EN
  // Any terminating byte still carrying the continuation bit is overlong or truncated.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_err <= 1'b0;
    end else if (take && term) begin
      out_err <= in_data[CONT_BIT];
    end else if (handoff) begin
      out_err <= 1'b0;
    end
  end
`else
  assign out_err = 1'b0;
`endif

  unpack_i32 u_unpack (
    .i0    (w[0]),
    .i1    (w[1]),
    .i2    (w[2]),
    .i3    (w[3]),
    .i4    (w[4]),
    .value (out_data),
    .len   (out_len)
  );

endmodule

// File: tb/tb_leb128_i32_stream_decoder.sv
// Directed table-driven bench for leb128_i32_stream_decoder (CNT_W shrunk to reach saturation).
module tb_leb128_i32_stream_decoder;

  localparam int TB_CNT_W = 3;
`ifdef LEB128_DECODER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic signed [31:0]  out_data;
  logic [2:0]          out_len;
  logic                out_err;
  logic                out_valid;
  logic                out_ready;
  logic [TB_CNT_W-1:0] value_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  leb128_i32_stream_decoder #(.CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .value_cnt (value_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] bytes;  // byte 0 in the most significant position
    int          n;
    bit          last;
    logic [31:0] d;
    logic [2:0]  len;
    bit          err;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input logic [39:0] bytes, input int n, input bit last,
                              input logic [31:0] d, input logic [2:0] len, input bit err);
    vec_t v;
    v.bytes = bytes; v.n = n; v.last = last; v.d = d; v.len = len; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    in_data = b; in_valid = 1'b1; in_last = last;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic bump_cnt();
    if (exp_cnt < (1 << TB_CNT_W) - 1) exp_cnt++;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    for (int i = 0; i < v.n; i++)
      send_byte(v.bytes[39 - 8*i -: 8], v.last && (i == v.n - 1));
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({name, "_data"}, out_data, v.d);
    chk({name, "_len"}, 32'(out_len), 32'(v.len));
    chk({name, "_err"}, 32'(out_err), ERR_EN ? 32'(v.err) : 32'd0);
    tick();
    bump_cnt();
    chk({name, "_handoff_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_cnt"}, 32'(value_cnt), 32'(exp_cnt));
  endtask

  initial begin
    vecs[0]  = mk(40'h0000000000, 1, 1'b0, 32'h00000000, 3'd1, 1'b0);
    vecs[1]  = mk(40'h9bf1590000, 3, 1'b0, 32'hFFF6789B, 3'd3, 1'b0);
    vecs[2]  = mk(40'hffffffff0f, 5, 1'b0, 32'hFFFFFFFF, 3'd5, 1'b0);
    vecs[3]  = mk(40'hffffffff8f, 5, 1'b0, 32'hFFFFFFFF, 3'd5, 1'b1);
    vecs[4]  = mk(40'h8000000000, 1, 1'b1, 32'h00000000, 3'd2, 1'b1);
    vecs[5]  = mk(40'h0500000000, 1, 1'b0, 32'h00000005, 3'd1, 1'b0);
    vecs[6]  = mk(40'h7f00000000, 1, 1'b0, 32'hFFFFFFFF, 3'd1, 1'b0);
    vecs[7]  = mk(40'he58e260000, 3, 1'b0, 32'h00098765, 3'd3, 1'b0);
    vecs[8]  = mk(40'h8080808078, 5, 1'b0, 32'h80000000, 3'd5, 1'b0);
    vecs[9]  = mk(40'hc000000000, 2, 1'b0, 32'h00000040, 3'd2, 1'b0);
    vecs[10] = mk(40'hff80000000, 2, 1'b1, 32'h0000007F, 3'd3, 1'b1);

    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_len", 32'(out_len), 32'd1);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_cnt", 32'(value_cnt), 32'd0);

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result held four cycles, pending byte not taken during EMIT.
    out_ready = 1'b0;
    send_byte(8'h05, 1'b0);
    in_data = 8'h7f; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_data%0d", i), out_data, 32'd5);
      chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
      tick();
    end
    chk("bp_cnt_held", 32'(value_cnt), 32'(exp_cnt));
    out_ready = 1'b1;
    tick();
    bump_cnt();
    chk("bp_handoff_valid", 32'(out_valid), 32'd0);
    chk("bp_handoff_in_ready", 32'(in_ready), 32'd1);
    chk("bp_handoff_cnt", 32'(value_cnt), 32'(exp_cnt));
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_data", out_data, 32'hFFFFFFFF);
    tick();
    bump_cnt();
    chk("bp_next_cnt", 32'(value_cnt), 32'(exp_cnt));

    // Reset in the middle of a value discards it and clears the counter.
    send_byte(8'h9b, 1'b0);
    send_byte(8'hf1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_cnt", 32'(value_cnt), 32'd0);
    run_vec("after_rst", vecs[5]);

    // Remaining vectors push the 3-bit counter past saturation.
    for (int i = 5; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    run_vec("sat", vecs[0]);
    chk("sat_cnt_ones", 32'(value_cnt), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
